// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with a per-grant hold limit, saturating grant-event
// counter and a sticky starvation flag driven by per-requester wait counters.
module rr_grant_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         arb_req,
   output logic [N-1:0]         arb_gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic [CNT_W-1:0]     grant_count,
   output logic                 starve_err
);

   // state | meaning
   // ------+-------------------------------------------------
   // IDLE  | no holder; arb_gnt all zero, waiting for a request
   // GRANT | requester h owns the resource, hold_cnt running

   localparam int IW    = $clog2(N);
   localparam int HW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int BOUND = (N - 1) * MAX_HOLD + 1;
   localparam int WW    = $clog2(BOUND + 2);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   h, h_n, h_inc, ptr, ptr_n, start, sel, cand;
   logic [IW:0]     sum;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic            found, grant_evt, any_over;
   logic [N-1:0]    gnt_n;
   logic [WW-1:0]   wait_cnt [N];

   assign h_inc = (h == IW'(N - 1)) ? '0 : h + 1'b1;

   // Searching from h+1 places h last, which is exactly the expiry rule;
   // after a drop arb_req[h] is low so h is never picked again.
   always_comb begin
      start = (state == ST_IDLE) ? ptr : h_inc;
      found = 1'b0;
      sel   = '0;
      sum   = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, start} + (IW+1)'(i);
         if (sum >= (IW+1)'(N))
            sum = sum - (IW+1)'(N);
         cand = sum[IW-1:0];
         if (arb_req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_n   = state;
      h_n       = h;
      ptr_n     = ptr;
      hold_n    = hold_cnt;
      grant_evt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_n   = ST_GRANT;
               h_n       = sel;
               hold_n    = '0;
               grant_evt = 1'b1;
            end
         end
         ST_GRANT: begin
            if (arb_req[h] && (hold_cnt != HW'(MAX_HOLD - 1))) begin
               hold_n = hold_cnt + 1'b1;
            end else begin
               ptr_n = h_inc;
               if (found) begin
                  h_n       = sel;
                  hold_n    = '0;
                  grant_evt = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  hold_n  = '0;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_n = '0;
      if (state_n == ST_GRANT)
         gnt_n[h_n] = 1'b1;
   end

   always_comb begin
      any_over = 1'b0;
      for (int i = 0; i < N; i++)
         if (wait_cnt[i] > WW'(BOUND))
            any_over = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         h           <= '0;
         ptr         <= '0;
         hold_cnt    <= '0;
         arb_gnt     <= '0;
         gnt_valid   <= 1'b0;
         gnt_id      <= '0;
         grant_count <= '0;
         starve_err  <= 1'b0;
         for (int i = 0; i < N; i++)
            wait_cnt[i] <= '0;
      end else begin
         state     <= state_n;
         h         <= h_n;
         ptr       <= ptr_n;
         hold_cnt  <= hold_n;
         arb_gnt   <= gnt_n;
         gnt_valid <= (state_n == ST_GRANT);
         gnt_id    <= (state_n == ST_GRANT) ? h_n : '0;
         if (grant_evt && (grant_count != {CNT_W{1'b1}}))
            grant_count <= grant_count + 1'b1;
         if (any_over)
            starve_err <= 1'b1;
         // Waiting is judged against the grant the requester currently sees.
         for (int i = 0; i < N; i++) begin
            if (!arb_req[i] || arb_gnt[i])
               wait_cnt[i] <= '0;
            else if (wait_cnt[i] != WW'(BOUND + 1))
               wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

endmodule
